fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and issues single-outstanding requests to a variable-latency instruction memory.
- Presents fetched instruction/address pairs to IF/ID, and drives IF/ID flush for branch redirects and fetch bubbles.
- Handles hazard-unit stalls and ID-stage branch redirects, including discarding in-flight wrong-path responses.

---
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, keeps one imem request in
// flight, and feeds the IF/ID register (instruction, address, valid, flush).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_addr_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        flush_o
);

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        HOLD
    } state_e;

    state_e      state;
    logic [31:0] pc_q;
    logic [31:0] buf_q;
    logic        kill_q;

    logic        rsp_live;
    logic        valid;

    // A response is only usable when it belongs to the current path.
    assign rsp_live = (state == WAIT) && imem_rvalid_i && !kill_q;

    assign valid = rst_i && !branch_taken_i
                   && (rsp_live || (state == HOLD));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= ISSUE;
            pc_q   <= RESET_PC;
            kill_q <= 1'b0;
            buf_q  <= '0;
        end else begin
            unique case (state)
                ISSUE: begin
                    state <= WAIT;
                    // The old-PC request is already out; mark it wrong-path.
                    if (branch_taken_i) begin
                        pc_q   <= branch_target_i;
                        kill_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        kill_q <= 1'b0;
                        state  <= ISSUE;
                        if (branch_taken_i) begin
                            pc_q <= branch_target_i;
                        end else if (!kill_q) begin
                            if (stall_i) begin
                                buf_q <= imem_rdata_i;
                                state <= HOLD;
                            end else begin
                                pc_q <= pc_q + PC_STEP;
                            end
                        end
                    end else if (branch_taken_i) begin
                        pc_q   <= branch_target_i;
                        kill_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (branch_taken_i) begin
                        pc_q  <= branch_target_i;
                        state <= ISSUE;
                    end else if (!stall_i) begin
                        pc_q  <= pc_q + PC_STEP;
                        state <= ISSUE;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end

    always_comb begin
        imem_req_o    = rst_i && (state == ISSUE);
        imem_addr_o   = pc_q;
        instr_valid_o = valid;
        instr_addr_o  = '0;
        instr_o       = '0;
        if (valid) begin
            instr_addr_o = pc_q;
            instr_o      = (state == HOLD) ? buf_q : imem_rdata_i;
        end
        flush_o = !rst_i || branch_taken_i || (!stall_i && !valid);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized stall/redirect/latency stimulus, with a fetch-stream
// reference model feeding a scoreboard that a separate monitor drains.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          NCYC   = 4000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_addr_o;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        flush_o;

    fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .instr_addr_o   (instr_addr_o),
        .instr_o        (instr_o),
        .instr_valid_o  (instr_valid_o),
        .flush_o        (flush_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;

    // Reference model: where the next fetch must go, and the one in flight.
    logic [31:0] fetch_pc;
    bit          busy;
    bit          killed;
    logic [31:0] req_addr;
    bit          exp_req;
    bit          exp_v;

    // Instruction memory model.
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        fetch_pc = RST_PC;
        busy     = 1'b0;
        killed   = 1'b0;
        pend     = 1'b0;
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 4))
            0:       return 32'hFFFF_FFF8;
            1:       return 32'hFFFF_FFFC;
            2:       return 32'h0000_0100;
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    // Producer: checks requests, tracks the in-flight fetch, and pushes the
    // instruction that must appear whenever a right-path response arrives.
    initial forever begin
        @(negedge clk_i);
        if (rst_i) begin
            exp_req = !busy && (exp_q.size() == 0);
            chk("imem_req", {31'b0, imem_req_o}, {31'b0, exp_req});
            if (imem_req_o) begin
                chk("imem_addr", imem_addr_o, fetch_pc);
                busy      = 1'b1;
                killed    = branch_taken_i;
                req_addr  = fetch_pc;
                pend      = 1'b1;
                pend_addr = imem_addr_o;
                pend_cnt  = $urandom_range(0, 3);
            end else if (imem_rvalid_i) begin
                if (!killed && !branch_taken_i)
                    exp_q.push_back('{req_addr, mem_word(req_addr)});
                busy = 1'b0;
            end else if (branch_taken_i && busy) begin
                killed = 1'b1;
            end
            if (branch_taken_i) begin
                exp_q.delete();
                fetch_pc = branch_target_i;
            end
        end
    end

    // Monitor: compares what IF/ID sees against the scoreboard head.
    initial forever begin
        @(negedge clk_i);
        #1;
        if (!rst_i) begin
            chk("rst_req", {31'b0, imem_req_o}, 32'd0);
            chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
            chk("rst_instr", instr_o, 32'd0);
            chk("rst_addr", instr_addr_o, 32'd0);
            chk("rst_flush", {31'b0, flush_o}, 32'd1);
        end else begin
            exp_v = exp_q.size() != 0;
            chk("instr_valid", {31'b0, instr_valid_o}, {31'b0, exp_v});
            chk("flush", {31'b0, flush_o},
                {31'b0, branch_taken_i || (!stall_i && !exp_v)});
            if (exp_v && instr_valid_o) begin
                chk("instr_addr", instr_addr_o, exp_q[0].addr);
                chk("instr", instr_o, exp_q[0].data);
            end
            if (!instr_valid_o) begin
                chk("idle_instr", instr_o, 32'd0);
                chk("idle_addr", instr_addr_o, 32'd0);
            end
            if (exp_v && !stall_i) begin
                fetch_pc = exp_q[0].addr + 32'd4;
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_i           = 1'b0;
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = '0;
        imem_rvalid_i   = 1'b0;
        imem_rdata_i    = '0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk_i);
            #1;
            if (c == NCYC / 2) begin
                rst_i = 1'b0;
                model_reset();
            end
            if (c == NCYC / 2 + 3) rst_i = 1'b1;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
            if (pend && rst_i) begin
                if (pend_cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_word(pend_addr);
                    pend          = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            stall_i         = ($urandom_range(0, 9) < 3);
            branch_taken_i  = ($urandom_range(0, 9) == 0);
            branch_target_i = branch_taken_i ? pick_target() : $urandom;
        end
        @(negedge clk_i);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
